// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB full-speed transmit path.
package usb_tx_pkg;

  localparam int unsigned MAX_BYTES_DFLT = 64;
  localparam int unsigned CNT_W          = 7;
  localparam int unsigned PID_W          = 4;
  localparam int unsigned EOP_W          = 2;

  localparam logic [7:0] SYNC_BYTE_DFLT = 8'h80;

  localparam logic [PID_W-1:0] PID_DATA0 = 4'b0011;
  localparam logic [PID_W-1:0] PID_DATA1 = 4'b1011;
  localparam logic [PID_W-1:0] PID_ACK   = 4'b0010;
  localparam logic [PID_W-1:0] PID_NAK   = 4'b1010;
  localparam logic [PID_W-1:0] PID_STALL = 4'b1110;

  typedef enum logic [3:0] {
    IDLE, LD_SYNC, TX_SYNC, LD_PID, TX_PID, LD_DATA, TX_DATA,
    LD_CRC_LO, TX_CRC_LO, LD_CRC_HI, TX_CRC_HI, EOP_SE0, EOP_J, DONE, ERROR
  } tx_state_t;

  function automatic logic pid_is_data(input logic [PID_W-1:0] pid);
    return (pid == PID_DATA0) || (pid == PID_DATA1);
  endfunction

  function automatic logic pid_is_legal(input logic [PID_W-1:0] pid);
    return pid_is_data(pid) || (pid == PID_ACK) || (pid == PID_NAK) || (pid == PID_STALL);
  endfunction

endpackage

// File: rtl/tcu_if.sv
// Signal bundle between endpoint logic, the TX datapath and the transmit control unit.
interface tcu_if;
  import usb_tx_pkg::*;

  logic             tx_start;
  logic [PID_W-1:0] tx_pid;
  logic [CNT_W-1:0] tx_count;
  logic [7:0]       fifo_rdata;
  logic             fifo_empty;
  logic [15:0]      crc16;
  logic             bit_tick;
  logic             byte_done;

  logic             load_en;
  logic [7:0]       load_data;
  logic             fifo_ren;
  logic             crc_clear;
  logic             crc_en;
  logic             tx_active;
  logic             se0_drive;
  logic             j_drive;
  logic             tx_done;
  logic             tx_error;

  modport master (
    input  tx_start, tx_pid, tx_count, fifo_rdata, fifo_empty, crc16, bit_tick, byte_done,
    output load_en, load_data, fifo_ren, crc_clear, crc_en, tx_active, se0_drive, j_drive,
           tx_done, tx_error
  );

  modport slave (
    output tx_start, tx_pid, tx_count, fifo_rdata, fifo_empty, crc16, bit_tick, byte_done,
    input  load_en, load_data, fifo_ren, crc_clear, crc_en, tx_active, se0_drive, j_drive,
           tx_done, tx_error
  );

endinterface

// File: rtl/tx_byte_counter.sv
// Loadable down-counter with a zero flag; saturates at zero.
module tx_byte_counter #(
  parameter int unsigned W = 7
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero_c
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                 cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (dec && !zero_c)    cnt <= cnt - W'(1);
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/tcu.sv
// USB full-speed transmit control unit: sequences SYNC, PID, payload, CRC16 and EOP
// into the byte shifter through a one-cycle load / byte_done handshake.
module tcu
  import usb_tx_pkg::*;
#(
  parameter int unsigned MAX_BYTES = MAX_BYTES_DFLT,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DFLT
) (
  input logic   clk,
  input logic   n_rst,
  tcu_if.master bus
);

  tx_state_t        state, nxt_c;
  logic [PID_W-1:0] pid_q;
  logic             abort_q;
  logic             start_c, start_ok_c, take_c;
  logic             rem_zero_c, eop_zero_c, eop_load_c;
  logic [EOP_W-1:0] eop_val_c;

  assign start_c    = (state == IDLE) && bus.tx_start;
  assign start_ok_c = pid_is_legal(bus.tx_pid) && (32'(bus.tx_count) <= MAX_BYTES);
  // A payload byte is taken only when the FIFO has one on entry to LD_DATA
  assign take_c     = (nxt_c == LD_DATA) && !bus.fifo_empty;

  // Remaining payload bytes
  tx_byte_counter #(.W(CNT_W)) u_rem (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (start_c),
    .load_val (bus.tx_count),
    .dec      (take_c),
    .zero_c   (rem_zero_c)
  );

  // Bit ticks left in the current EOP phase, loaded as (ticks - 1) on entry
  assign eop_load_c = ((nxt_c == EOP_SE0) && (state != EOP_SE0)) ||
                      ((nxt_c == EOP_J)   && (state != EOP_J));
  assign eop_val_c  = (nxt_c == EOP_SE0) ? EOP_W'(1) : EOP_W'(0);

  tx_byte_counter #(.W(EOP_W)) u_eop (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (eop_load_c),
    .load_val (eop_val_c),
    .dec      (bus.bit_tick),
    .zero_c   (eop_zero_c)
  );

  // Next-state decode
  always_comb begin
    nxt_c = state;
    unique case (state)
      IDLE:      if (bus.tx_start) nxt_c = start_ok_c ? LD_SYNC : ERROR;
      LD_SYNC:   nxt_c = TX_SYNC;
      TX_SYNC:   if (bus.byte_done) nxt_c = LD_PID;
      LD_PID:    nxt_c = TX_PID;
      TX_PID:    if (bus.byte_done) begin
                   if (!pid_is_data(pid_q)) nxt_c = EOP_SE0;
                   else                     nxt_c = rem_zero_c ? LD_CRC_LO : LD_DATA;
                 end
      LD_DATA:   nxt_c = bus.load_en ? TX_DATA : EOP_SE0;
      TX_DATA:   if (bus.byte_done) nxt_c = rem_zero_c ? LD_CRC_LO : LD_DATA;
      LD_CRC_LO: nxt_c = TX_CRC_LO;
      TX_CRC_LO: if (bus.byte_done) nxt_c = LD_CRC_HI;
      LD_CRC_HI: nxt_c = TX_CRC_HI;
      TX_CRC_HI: if (bus.byte_done) nxt_c = EOP_SE0;
      EOP_SE0:   if (bus.bit_tick && eop_zero_c) nxt_c = EOP_J;
      EOP_J:     if (bus.bit_tick && eop_zero_c) nxt_c = DONE;
      DONE:      nxt_c = IDLE;
      ERROR:     nxt_c = IDLE;
      default:   nxt_c = IDLE;
    endcase
  end

  // State register; every output is registered from the state being entered
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      pid_q         <= '0;
      abort_q       <= 1'b0;
      bus.load_en   <= 1'b0;
      bus.load_data <= 8'h00;
      bus.fifo_ren  <= 1'b0;
      bus.crc_clear <= 1'b0;
      bus.crc_en    <= 1'b0;
      bus.tx_active <= 1'b0;
      bus.se0_drive <= 1'b0;
      bus.j_drive   <= 1'b0;
      bus.tx_done   <= 1'b0;
      bus.tx_error  <= 1'b0;
    end else begin
      state <= nxt_c;
      if (start_c) pid_q <= bus.tx_pid;

      if (state == DONE)                             abort_q <= 1'b0;
      else if ((nxt_c == LD_DATA) && bus.fifo_empty) abort_q <= 1'b1;

      bus.load_en   <= take_c || (nxt_c inside {LD_SYNC, LD_PID, LD_CRC_LO, LD_CRC_HI});
      bus.fifo_ren  <= take_c;
      bus.crc_en    <= take_c;
      bus.crc_clear <= (state == IDLE) && (nxt_c == LD_SYNC);
      bus.tx_active <= !(nxt_c inside {IDLE, DONE, ERROR});
      bus.se0_drive <= (nxt_c == EOP_SE0);
      bus.j_drive   <= (nxt_c == EOP_J);
      bus.tx_done   <= (nxt_c inside {DONE, ERROR});
      bus.tx_error  <= (nxt_c == ERROR) || ((nxt_c == DONE) && abort_q);

      case (nxt_c)
        LD_SYNC:   bus.load_data <= SYNC_BYTE;
        LD_PID:    bus.load_data <= {~pid_q, pid_q};
        LD_DATA:   if (take_c) bus.load_data <= bus.fifo_rdata;
        LD_CRC_LO: bus.load_data <= bus.crc16[7:0];
        LD_CRC_HI: bus.load_data <= bus.crc16[15:8];
        default:   ;
      endcase
    end
  end

endmodule

// File: tb/tb_tcu.sv
// Bench for tcu: environment models the FIFO, shifter and bit clock; a packet-level model
// predicts the loaded byte stream, pop count, EOP length and error flag.
module tb_tcu;
  import usb_tx_pkg::*;

  localparam int TPER = 4;

  logic clk = 1'b0;
  logic n_rst;

  tcu_if bus ();

  tcu u_dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0]  fifo_q[$];
  logic [7:0]  exp_q[$];
  logic        exp_err;
  logic        exp_legal;
  int          exp_ren;
  int          ren_cnt, clr_cnt, se0_ticks, j_ticks, act_cycles, done_cnt;
  logic        done_err;
  logic [63:0] seen_pack;
  int          seen_n;
  logic        busy;
  int          tleft;
  int          tphase;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [16:0] outs();
    return {bus.load_en, bus.load_data, bus.fifo_ren, bus.crc_clear, bus.crc_en,
            bus.tx_active, bus.se0_drive, bus.j_drive, bus.tx_done, bus.tx_error};
  endfunction

  // Per-cycle observation of DUT outputs and their effect on the environment
  task automatic monitor();
    logic [7:0] d;
    check_eq("crc_en_eq_fifo_ren", bus.crc_en, bus.fifo_ren);
    check_eq("ren_without_load", bus.fifo_ren & ~bus.load_en, 0);
    check_eq("se0_and_j", bus.se0_drive & bus.j_drive, 0);
    check_eq("line_when_inactive", (bus.load_en | bus.se0_drive | bus.j_drive) & ~bus.tx_active, 0);
    check_eq("error_without_done", bus.tx_error & ~bus.tx_done, 0);
    if (bus.load_en) begin
      seen_pack = {seen_pack[55:0], bus.load_data};
      seen_n++;
      busy  = 1'b1;
      tleft = 8;
      check_eq("load_expected", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        d = exp_q.pop_front();
        check_eq("load_data", bus.load_data, d);
      end
    end
    if (bus.fifo_ren) begin
      ren_cnt++;
      check_eq("pop_nonempty", 64'(fifo_q.size() != 0), 1);
      if (fifo_q.size() != 0) d = fifo_q.pop_front();
    end
    if (bus.crc_clear) clr_cnt++;
    if (bus.se0_drive && bus.bit_tick) se0_ticks++;
    if (bus.j_drive && bus.bit_tick) j_ticks++;
    if (bus.tx_active) act_cycles++;
    if (bus.tx_done) begin
      done_cnt++;
      done_err = bus.tx_error;
    end
  endtask

  // One clock: drive environment inputs for this cycle, then observe
  task automatic tick();
    @(posedge clk);
    #1;
    bus.bit_tick  = (tphase == 0);
    tphase        = (tphase + 1) % TPER;
    bus.byte_done = busy && bus.bit_tick && (tleft == 1);
    if (!busy && ($urandom_range(3) == 0)) bus.byte_done = 1'b1;
    bus.fifo_empty = (fifo_q.size() == 0);
    bus.fifo_rdata = bus.fifo_empty ? 8'($urandom) : fifo_q[0];
    if (busy && bus.bit_tick) begin
      tleft--;
      if (tleft == 0) busy = 1'b0;
    end
    if (n_rst) monitor();
  endtask

  task automatic start_pkt(input logic [3:0] pid, input logic [6:0] cnt, input logic [15:0] crc);
    int   n;
    logic is_data;
    is_data   = (pid == 4'b0011) || (pid == 4'b1011);
    exp_legal = (is_data || pid == 4'b0010 || pid == 4'b1010 || pid == 4'b1110) && (int'(cnt) <= 64);
    exp_q.delete();
    exp_ren = 0;
    exp_err = !exp_legal;
    if (exp_legal) begin
      exp_q.push_back(8'h80);
      exp_q.push_back({~pid, pid});
      if (is_data) begin
        n = (fifo_q.size() < int'(cnt)) ? fifo_q.size() : int'(cnt);
        for (int i = 0; i < n; i++) exp_q.push_back(fifo_q[i]);
        exp_ren = n;
        if (n == int'(cnt)) begin
          exp_q.push_back(crc[7:0]);
          exp_q.push_back(crc[15:8]);
        end else begin
          exp_err = 1'b1;
        end
      end
    end
    ren_cnt = 0; clr_cnt = 0; se0_ticks = 0; j_ticks = 0; act_cycles = 0; done_cnt = 0;
    done_err = 1'b0; seen_pack = '0; seen_n = 0;
    bus.crc16    = crc;
    bus.tx_pid   = pid;
    bus.tx_count = cnt;
    bus.tx_start = 1'b1;
    tick();
    bus.tx_start = 1'b0;
    if (exp_legal) check_eq("start_to_sync_load", {bus.load_en, bus.load_data}, {1'b1, 8'h80});
    else check_eq("reject_pulse", {bus.tx_done, bus.tx_error, bus.tx_active, bus.load_en}, 4'b1100);
  endtask

  task automatic finish_pkt();
    for (int i = 0; i < 4000 && done_cnt == 0; i++) begin
      tick();
      bus.tx_start = bus.tx_active && ($urandom_range(15) == 0);
      if (bus.tx_start) begin
        bus.tx_pid   = 4'($urandom);
        bus.tx_count = 7'($urandom);
      end
    end
    bus.tx_start = 1'b0;
    repeat (3) tick();
    check_eq("done_pulses", done_cnt, 1);
    check_eq("tx_error", done_err, exp_err);
    check_eq("loads_missing", exp_q.size(), 0);
    check_eq("fifo_ren_count", ren_cnt, exp_ren);
    check_eq("crc_clear_count", clr_cnt, exp_legal);
    check_eq("se0_bit_ticks", se0_ticks, exp_legal ? 2 : 0);
    check_eq("j_bit_ticks", j_ticks, exp_legal ? 1 : 0);
    if (!exp_legal) check_eq("reject_active_cycles", act_cycles, 0);
    check_eq("idle_after_done", bus.tx_active, 0);
  endtask

  initial begin
    logic [3:0] pid;
    int         cnt;
    int         nf;
    int         r;

    bus.tx_start = 1'b0; bus.tx_pid = '0; bus.tx_count = '0; bus.fifo_rdata = '0;
    bus.fifo_empty = 1'b1; bus.crc16 = '0; bus.bit_tick = 1'b0; bus.byte_done = 1'b0;
    busy = 1'b0; tleft = 0; tphase = 0; seen_pack = '0; seen_n = 0;
    ren_cnt = 0; clr_cnt = 0; se0_ticks = 0; j_ticks = 0; act_cycles = 0; done_cnt = 0;
    done_err = 1'b0; exp_err = 1'b0; exp_legal = 1'b0; exp_ren = 0;

    n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs", outs(), 0);
    n_rst = 1'b1;
    repeat (2) tick();

    // ACK handshake
    fifo_q.delete(); fifo_q.push_back(8'h77);
    start_pkt(4'b0010, 7'd0, 16'h1234);
    finish_pkt();
    check_eq("ack_nloads", seen_n, 2);
    check_eq("ack_bytes", seen_pack[15:0], 16'h80D2);
    check_eq("ack_no_ren", ren_cnt, 0);

    // DATA0 with three payload bytes
    fifo_q.delete(); fifo_q.push_back(8'h11); fifo_q.push_back(8'h22); fifo_q.push_back(8'h33);
    start_pkt(4'b0011, 7'd3, 16'hBEEF);
    finish_pkt();
    check_eq("data0_nloads", seen_n, 7);
    check_eq("data0_bytes", seen_pack[55:0], 56'h80C3112233EFBE);
    check_eq("data0_ren", ren_cnt, 3);
    check_eq("data0_err", done_err, 0);

    // DATA1 underrun: two requested, one available
    fifo_q.delete(); fifo_q.push_back(8'h5A);
    start_pkt(4'b1011, 7'd2, 16'hCAFE);
    finish_pkt();
    check_eq("underrun_nloads", seen_n, 3);
    check_eq("underrun_bytes", seen_pack[23:0], 24'h804B5A);
    check_eq("underrun_err", done_err, 1);
    check_eq("underrun_ren", ren_cnt, 1);

    // Rejections: illegal PID, oversize count
    fifo_q.delete();
    start_pkt(4'b0001, 7'd1, 16'h0000);
    finish_pkt();
    check_eq("bad_pid_loads", seen_n, 0);
    check_eq("bad_pid_err", done_err, 1);
    start_pkt(4'b0011, 7'd65, 16'h0000);
    finish_pkt();
    check_eq("oversize_loads", seen_n, 0);

    // Boundary: count = 64 with FIFO underrun still accepted
    fifo_q.delete(); fifo_q.push_back(8'hE1);
    start_pkt(4'b0011, 7'd64, 16'h0000);
    finish_pkt();
    check_eq("max_count_accepted", clr_cnt, 1);

    // Zero-length DATA0
    fifo_q.delete(); fifo_q.push_back(8'h99);
    start_pkt(4'b0011, 7'd0, 16'hA55A);
    finish_pkt();
    check_eq("zlp_nloads", seen_n, 4);
    check_eq("zlp_bytes", seen_pack[31:0], 32'h80C35AA5);
    check_eq("zlp_ren", ren_cnt, 0);

    // Reset in the middle of the payload, then a clean packet
    fifo_q.delete();
    for (int i = 0; i < 10; i++) fifo_q.push_back(8'($urandom));
    start_pkt(4'b1011, 7'd10, 16'h1111);
    for (int i = 0; i < 2000 && ren_cnt < 3; i++) tick();
    check_eq("reached_payload", 64'(ren_cnt >= 3), 1);
    n_rst = 1'b0;
    #1;
    check_eq("midpacket_reset_outputs", outs(), 0);
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    busy = 1'b0; fifo_q.delete(); exp_q.delete();
    fifo_q.push_back(8'hA1); fifo_q.push_back(8'hB2);
    start_pkt(4'b0011, 7'd2, 16'h0F0E);
    finish_pkt();
    check_eq("post_reset_nloads", seen_n, 6);
    check_eq("post_reset_bytes", seen_pack[47:0], 48'h80C3A1B20E0F);

    // Randomized packets
    for (int p = 0; p < 40; p++) begin
      r = $urandom_range(9);
      case (r)
        0, 1, 2: pid = 4'b0011;
        3, 4, 5: pid = 4'b1011;
        6:       pid = 4'b0010;
        7:       pid = 4'b1010;
        8:       pid = 4'b1110;
        default: pid = 4'($urandom);
      endcase
      cnt = ($urandom_range(15) == 0) ? $urandom_range(127, 60) : $urandom_range(12);
      nf  = (cnt > 20) ? 20 : cnt;
      if ($urandom_range(3) == 0) nf = $urandom_range(nf);
      fifo_q.delete();
      for (int i = 0; i < nf; i++) fifo_q.push_back(8'($urandom));
      start_pkt(pid, 7'(cnt), 16'($urandom));
      finish_pkt();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tcu.md
Name: tcu

Overview:
- Transmit control unit for the USB full-speed device endpoint; the TX-side counterpart of the receive controller.
- Sequences one outgoing packet: SYNC byte, PID byte, payload bytes from the TX FIFO, CRC16, then EOP.
- Drives the TX byte shift register (which also does bit stuffing and NRZI) through a one-cycle load/byte_done handshake.
- Sits between the endpoint protocol logic (tx_start/tx_pid) and the TX datapath (FIFO, CRC16, shifter, line driver).

Parameters:
MAX_BYTES, 64, largest payload accepted; a larger tx_count is an error
SYNC_BYTE, 8'h80, SYNC pattern loaded into the shifter

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
tx_start  in  1  start-packet request; sampled only in IDLE
tx_pid  in  4  PID to send; latched on accepted tx_start
tx_count  in  7  payload byte count; latched on accepted tx_start
fifo_rdata  in  8  TX FIFO head, first-word-fall-through
fifo_empty  in  1  TX FIFO empty
crc16  in  16  final (inverted) CRC16 from the CRC unit
bit_tick  in  1  one-clk strobe per USB bit period
byte_done  in  1  shifter pulse when the last bit of the loaded byte leaves
load_en  out  1  one-clk pulse: shifter captures load_data
load_data  out  8  byte presented to the shifter
fifo_ren  out  1  one-clk FIFO pop
crc_clear  out  1  one-clk CRC reset before payload
crc_en  out  1  CRC accumulates load_data this cycle
tx_active  out  1  packet in progress (SYNC through EOP)
se0_drive  out  1  force SE0 on the line
j_drive  out  1  force J on the line
tx_done  out  1  one-clk pulse: packet finished
tx_error  out  1  one-clk pulse with tx_done when the packet was aborted or rejected

Behaviour:
- Reset: state IDLE; all outputs 0; load_data 8'h00; latched pid/count 0. Reset mid-packet returns to IDLE immediately with no EOP. The shifter shares n_rst.
- States: IDLE, LD_SYNC, TX_SYNC, LD_PID, TX_PID, LD_DATA, TX_DATA, LD_CRC_LO, TX_CRC_LO, LD_CRC_HI, TX_CRC_HI, EOP_SE0, EOP_J, DONE, ERROR.
- IDLE, tx_start=1:
  - Latch pid and count; go to ERROR if the PID is illegal or count > MAX_BYTES.
  - Legal PIDs: DATA0 4'b0011, DATA1 4'b1011, ACK 4'b0010, NAK 4'b1010, STALL 4'b1110.
  - Otherwise go to LD_SYNC and assert crc_clear in the same cycle.
- LD_x states: load_en=1 for exactly one cycle, then go to TX_x. TX_x states wait for byte_done. byte_done in any LD or non-TX state is ignored.
- load_data per state:
  - LD_SYNC: SYNC_BYTE.
  - LD_PID: {~pid, pid}.
  - LD_DATA: fifo_rdata.
  - LD_CRC_LO: crc16[7:0].
  - LD_CRC_HI: crc16[15:8].
- After TX_PID:
  - Handshake PIDs go to EOP_SE0.
  - DATA PIDs with count = 0 go to LD_CRC_LO (CRC 16'h0000-derived value from datapath).
  - Otherwise go to LD_DATA.
- LD_DATA:
  - fifo_empty=0: load_en, fifo_ren and crc_en assert together; remaining count decrements.
  - fifo_empty=1 (underrun): no load, no pop; set the abort flag; go to EOP_SE0.
- TX_DATA on byte_done: remaining = 0 goes to LD_CRC_LO, else LD_DATA. LD_CRC_LO waits one cycle after the final data byte so crc16 is settled.
- tx_active = 1 in every state except IDLE, DONE and ERROR.
- EOP:
  - EOP_SE0: se0_drive=1, entered on the bit_tick-aligned byte_done; held for 2 bit_ticks.
  - EOP_J: j_drive=1 for 1 bit_tick.
  - Then DONE.
- DONE: tx_done=1 for one cycle; tx_error=1 if the abort flag is set; clear the flag; go to IDLE.
- ERROR: tx_done=1 and tx_error=1 for one cycle; no line activity; go to IDLE.
- tx_start outside IDLE is ignored (not queued).
- Latency from tx_start to first load_en (SYNC): 1 clk.

Decomposition:
- Package usb_tx_pkg:
  - state enum tx_state_t.
  - PID constants PID_DATA0/DATA1/ACK/NAK/STALL.
  - SYNC_BYTE default, MAX_BYTES.
- Sub-module tx_byte_counter: 7-bit loadable down-counter with a zero flag. Also reused for the 2-bit EOP bit_tick count via parameterized width.

Test Plan:
- ACK (tx_pid=4'b0010), tx_start pulse -> load_data sequence 8'h80, 8'hD2; 2 bit_ticks se0_drive, 1 bit_tick j_drive; tx_done=1, tx_error=0; no fifo_ren.
- DATA0, count=3, FIFO {8'h11,8'h22,8'h33}, crc16=16'hBEEF -> loads 80,C3,11,22,33,EF,BE; exactly 3 fifo_ren and 3 crc_en; crc_clear once at start.
- DATA1, count=2, FIFO holds 1 byte -> loads 80,4B,xx; underrun then EOP; tx_done with tx_error=1; 1 fifo_ren.
- tx_pid=4'b0001 or count=65 -> ERROR; tx_done+tx_error pulse; no load_en, tx_active stays 0.
- DATA0 count=0 -> 80,C3, then CRC low/high bytes, EOP, tx_done; no fifo_ren.
- n_rst low during TX_DATA -> all outputs 0 next edge; a subsequent tx_start produces a clean full packet.
